// File: rtl/host_dpi_axil_bridge_if.sv
// host_dpi_axil_bridge_if: AXI4-Lite channel bundle between the bridge and the CSR slave
interface host_dpi_axil_bridge_if #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32
);
    logic                   awvalid;
    logic                   awready;
    logic [ADDR_BITS-1:0]   awaddr;
    logic                   wvalid;
    logic                   wready;
    logic [DATA_BITS-1:0]   wdata;
    logic [DATA_BITS/8-1:0] wstrb;
    logic                   bvalid;
    logic                   bready;
    logic [1:0]             bresp;
    logic                   arvalid;
    logic                   arready;
    logic [ADDR_BITS-1:0]   araddr;
    logic                   rvalid;
    logic                   rready;
    logic [DATA_BITS-1:0]   rdata;
    logic [1:0]             rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/host_dpi_axil_bridge.sv
// host_dpi_axil_bridge: turns one host DPI register request at a time into one AXI4-Lite master transaction
module host_dpi_axil_bridge #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  dpi_req_valid,
    input  logic                  dpi_req_opcode,
    input  logic [ADDR_BITS-1:0]  dpi_req_addr,
    input  logic [DATA_BITS-1:0]  dpi_req_value,
    output logic                  dpi_req_deq,
    output logic                  dpi_resp_valid,
    output logic [DATA_BITS-1:0]  dpi_resp_bits,
    host_dpi_axil_bridge_if.master m,
    output logic                  axi_err
);
    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t               state, state_n;
    logic                 aw_done, w_done;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] data_q;

    assign m.awaddr = addr_q;
    assign m.araddr = addr_q;
    assign m.wdata  = data_q;
    assign m.wstrb  = '1;

    // Next state and handshake outputs; AW/W completion is judged from done flags plus ready,
    // since each valid is simply the inverse of its done flag while in WR
    always_comb begin
        state_n     = state;
        dpi_req_deq = 1'b0;
        m.awvalid   = 1'b0;
        m.wvalid    = 1'b0;
        m.bready    = 1'b0;
        m.arvalid   = 1'b0;
        m.rready    = 1'b0;
        case (state)
            IDLE: begin
                dpi_req_deq = dpi_req_valid;
                state_n     = dpi_req_valid ? (dpi_req_opcode ? WR : RD_ADDR) : IDLE;
            end
            WR: begin
                m.awvalid = !aw_done;
                m.wvalid  = !w_done;
                state_n   = ((aw_done || m.awready) && (w_done || m.wready)) ? WR_RESP : WR;
            end
            WR_RESP: begin
                m.bready = 1'b1;
                state_n  = m.bvalid ? IDLE : WR_RESP;
            end
            RD_ADDR: begin
                m.arvalid = 1'b1;
                state_n   = m.arready ? RD_DATA : RD_ADDR;
            end
            RD_DATA: begin
                m.rready = 1'b1;
                state_n  = m.rvalid ? IDLE : RD_DATA;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, request capture, write done flags, read response pulse and sticky error
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            dpi_resp_valid <= 1'b0;
            dpi_resp_bits  <= '0;
            axi_err        <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && dpi_req_valid) begin
                addr_q <= dpi_req_addr;
                data_q <= dpi_req_value;
            end
            aw_done        <= state == WR && state_n == WR && (aw_done || m.awready);
            w_done         <= state == WR && state_n == WR && (w_done || m.wready);
            dpi_resp_valid <= state == RD_DATA && m.rvalid;
            if (state == RD_DATA && m.rvalid)
                dpi_resp_bits <= m.rdata;
            if ((state == WR_RESP && m.bvalid && m.bresp != 2'b00) ||
                (state == RD_DATA && m.rvalid && m.rresp != 2'b00))
                axi_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_host_dpi_axil_bridge.sv
// tb_host_dpi_axil_bridge: directed and randomized checks of the DPI to AXI-Lite bridge against a memory model
module tb_host_dpi_axil_bridge;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dpi_req_valid = 1'b0;
    logic        dpi_req_opcode = 1'b0;
    logic [7:0]  dpi_req_addr = '0;
    logic [31:0] dpi_req_value = '0;
    logic        dpi_req_deq;
    logic        dpi_resp_valid;
    logic [31:0] dpi_resp_bits;
    logic        axi_err;

    int total = 0;
    int bad = 0;

    // observations of the last transaction
    int          n_deq, n_aw, n_w, n_b, n_ar, n_r, n_resp;
    int          c_deq, c_aw, c_w, c_b, c_ar, c_r, c_resp;
    int          aw_valid_cycles;
    bit          unstable;
    logic [7:0]  obs_awaddr, obs_araddr;
    logic [31:0] obs_wdata, resp_data;
    logic [3:0]  obs_wstrb;

    host_dpi_axil_bridge_if #(.ADDR_BITS(8), .DATA_BITS(32)) bus ();

    host_dpi_axil_bridge #(.ADDR_BITS(8), .DATA_BITS(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .dpi_req_valid  (dpi_req_valid),
        .dpi_req_opcode (dpi_req_opcode),
        .dpi_req_addr   (dpi_req_addr),
        .dpi_req_value  (dpi_req_value),
        .dpi_req_deq    (dpi_req_deq),
        .dpi_resp_valid (dpi_resp_valid),
        .dpi_resp_bits  (dpi_resp_bits),
        .m              (bus),
        .axi_err        (axi_err)
    );

    always #5 clock = ~clock;

    // Host driver plus AXI-Lite slave for one request; inputs change on the falling edge, outputs sampled 1ns later
    task automatic run_txn(input bit op, input logic [7:0] a, input logic [31:0] v,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input int ar_dly, input int r_dly,
                           input logic [31:0] rd, input logic [1:0] rsp, input int hold, input int tail);
        int k, post, aw_wait, w_wait, ar_wait, b_wait, r_wait;
        bit deq_seen, aw_hs, w_hs, ar_hs, fin, prev_aw, prev_w, prev_ar;
        logic [7:0]  aw_hold, ar_hold;
        logic [31:0] w_hold;
        n_deq = 0; n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; n_resp = 0;
        c_deq = -1; c_aw = -1; c_w = -1; c_b = -1; c_ar = -1; c_r = -1; c_resp = -1;
        aw_valid_cycles = 0; unstable = 0; resp_data = 'x;
        k = 0; post = 0; aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
        deq_seen = 0; aw_hs = 0; w_hs = 0; ar_hs = 0; fin = 0;
        prev_aw = 0; prev_w = 0; prev_ar = 0;
        aw_hold = '0; ar_hold = '0; w_hold = '0;
        while (!(fin && post >= tail)) begin
            if (k >= 200) begin
                total++; bad++;
                $display("FAIL timeout: transaction op=%0d addr=%h did not finish within 200 cycles", op, a);
                break;
            end
            @(negedge clock);
            dpi_req_valid  = !deq_seen || (k - c_deq) <= hold;
            dpi_req_opcode = op;
            dpi_req_addr   = a;
            dpi_req_value  = v;
            bus.awready = aw_wait >= aw_dly;
            bus.wready  = w_wait >= w_dly;
            bus.arready = ar_wait >= ar_dly;
            bus.bvalid  = aw_hs && w_hs && !fin && b_wait >= b_dly;
            bus.bresp   = rsp;
            bus.rvalid  = ar_hs && !fin && r_wait >= r_dly;
            bus.rdata   = rd;
            bus.rresp   = rsp;
            #1;
            if (dpi_req_deq) begin
                n_deq++;
                if (!deq_seen) begin deq_seen = 1; c_deq = k; end
            end
            if (dpi_resp_valid) begin n_resp++; resp_data = dpi_resp_bits; c_resp = k; end
            if (bus.bvalid && bus.bready) begin n_b++; c_b = k; fin = 1; end
            else if (aw_hs && w_hs && !fin) b_wait++;
            if (bus.rvalid && bus.rready) begin n_r++; c_r = k; fin = 1; end
            else if (ar_hs && !fin) r_wait++;
            if (prev_aw && (!bus.awvalid || bus.awaddr !== aw_hold)) unstable = 1;
            if (prev_w && (!bus.wvalid || bus.wdata !== w_hold)) unstable = 1;
            if (prev_ar && (!bus.arvalid || bus.araddr !== ar_hold)) unstable = 1;
            prev_aw = 0; prev_w = 0; prev_ar = 0;
            if (bus.awvalid) begin
                aw_valid_cycles++;
                if (bus.awready) begin n_aw++; aw_hs = 1; c_aw = k; obs_awaddr = bus.awaddr; end
                else begin aw_wait++; prev_aw = 1; aw_hold = bus.awaddr; end
            end
            if (bus.wvalid) begin
                if (bus.wready) begin n_w++; w_hs = 1; c_w = k; obs_wdata = bus.wdata; obs_wstrb = bus.wstrb; end
                else begin w_wait++; prev_w = 1; w_hold = bus.wdata; end
            end
            if (bus.arvalid) begin
                if (bus.arready) begin n_ar++; ar_hs = 1; c_ar = k; obs_araddr = bus.araddr; end
                else begin ar_wait++; prev_ar = 1; ar_hold = bus.araddr; end
            end
            if (fin) post++;
            k++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        dpi_req_valid = 0;
        reset = 1;
        @(negedge clock);
        reset = 0;
    endtask

    task automatic test_reset();
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
        dpi_req_valid = 0;
        reset = 1;
        repeat (3) @(negedge clock);
        #1;
        total++;
        if ({dpi_req_deq, dpi_resp_valid, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: deq/resp/aw/w/b/ar/r=%b expected 0000000",
                     {dpi_req_deq, dpi_resp_valid, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
        end
        total++;
        if (dpi_resp_bits !== 32'h0) begin bad++; $display("FAIL reset_bits: got %h expected 00000000", dpi_resp_bits); end
        total++;
        if (axi_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b expected 0", axi_err); end
        @(negedge clock);
        reset = 0;
    endtask

    task automatic test_write_basic();
        run_txn(1'b1, 8'h04, 32'h0000_0001, 0, 0, 0, 0, 0, 32'h0, 2'b00, 0, 3);
        total++;
        if (n_deq !== 1 || c_deq !== 0) begin bad++; $display("FAIL wr_deq: count=%0d at=%0d expected 1 at 0", n_deq, c_deq); end
        total++;
        if (c_aw !== 1 || c_w !== 1) begin bad++; $display("FAIL wr_same_cycle: aw at %0d w at %0d expected both 1", c_aw, c_w); end
        total++;
        if (obs_awaddr !== 8'h04 || obs_wdata !== 32'h1 || obs_wstrb !== 4'hF) begin
            bad++; $display("FAIL wr_fields: awaddr=%h wdata=%h wstrb=%h expected 04 00000001 f", obs_awaddr, obs_wdata, obs_wstrb);
        end
        total++;
        if (c_b !== 2) begin bad++; $display("FAIL wr_bresp_cycle: got %0d expected 2", c_b); end
        total++;
        if (n_resp !== 0 || axi_err !== 1'b0) begin bad++; $display("FAIL wr_no_resp: pulses=%0d err=%b expected 0 0", n_resp, axi_err); end
    endtask

    task automatic test_write_aw_delay();
        run_txn(1'b1, 8'h0C, 32'h1234_5678, 3, 0, 0, 0, 0, 32'h0, 2'b00, 0, 3);
        total++;
        if (c_w !== 1 || c_aw !== 4) begin bad++; $display("FAIL aw_delay_order: w at %0d aw at %0d expected 1 and 4", c_w, c_aw); end
        total++;
        if (aw_valid_cycles !== 4 || unstable !== 1'b0) begin
            bad++; $display("FAIL aw_delay_hold: awvalid cycles=%0d unstable=%b expected 4 0", aw_valid_cycles, unstable);
        end
        total++;
        if (c_b !== 5 || n_w !== 1 || obs_awaddr !== 8'h0C) begin
            bad++; $display("FAIL aw_delay_resp: b at %0d w count=%0d awaddr=%h expected 5 1 0c", c_b, n_w, obs_awaddr);
        end
    endtask

    task automatic test_read_delay();
        run_txn(1'b0, 8'h08, 32'h0, 0, 0, 0, 0, 0, 32'h0BAD_F00D, 2'b00, 0, 3);
        total++;
        if (c_ar !== 1 || c_r !== 2 || c_resp !== 3) begin
            bad++; $display("FAIL rd_latency: ar=%0d r=%0d resp=%0d expected 1 2 3", c_ar, c_r, c_resp);
        end
        run_txn(1'b0, 8'h08, 32'h0, 0, 0, 0, 0, 2, 32'hDEAD_BEEF, 2'b00, 0, 3);
        total++;
        if (n_resp !== 1 || resp_data !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL rd_data: pulses=%0d data=%h expected 1 deadbeef", n_resp, resp_data);
        end
        total++;
        if (obs_araddr !== 8'h08 || c_resp !== c_r + 1 || c_r !== c_ar + 3) begin
            bad++; $display("FAIL rd_timing: araddr=%h ar=%0d r=%0d resp=%0d expected 08, r=ar+3, resp=r+1", obs_araddr, c_ar, c_r, c_resp);
        end
        @(negedge clock); #1;
        total++;
        if (dpi_resp_bits !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd_hold: bits=%h expected deadbeef", dpi_resp_bits); end
    endtask

    task automatic test_back_to_back();
        int xfers, pulses;
        logic [31:0] wd;
        run_txn(1'b1, 8'h10, 32'hA5A5_A5A5, 0, 0, 0, 0, 0, 32'h0, 2'b00, 1, 1);
        xfers = n_aw; pulses = n_resp; wd = obs_wdata;
        total++;
        if (n_deq !== 1 || c_b !== 2) begin bad++; $display("FAIL b2b_write: deq=%0d b at %0d expected 1 2", n_deq, c_b); end
        run_txn(1'b0, 8'h10, 32'h0, 0, 0, 0, 0, 0, wd, 2'b00, 1, 3);
        xfers += n_ar; pulses += n_resp;
        total++;
        if (n_deq !== 1 || c_deq !== 0) begin bad++; $display("FAIL b2b_read_accept: deq=%0d at=%0d expected 1 at 0", n_deq, c_deq); end
        total++;
        if (xfers !== 2 || pulses !== 1 || resp_data !== 32'hA5A5_A5A5) begin
            bad++; $display("FAIL b2b_totals: xfers=%0d pulses=%0d data=%h expected 2 1 a5a5a5a5", xfers, pulses, resp_data);
        end
    endtask

    task automatic test_rd_err();
        logic [31:0] rd;
        rd = $urandom;
        run_txn(1'b0, 8'h30, 32'h0, 0, 0, 0, 1, 1, rd, 2'b10, 0, 3);
        total++;
        if (n_resp !== 1 || resp_data !== rd || axi_err !== 1'b1) begin
            bad++; $display("FAIL rd_err: pulses=%0d data=%h err=%b expected 1 %h 1", n_resp, resp_data, axi_err, rd);
        end
        run_txn(1'b1, 8'h34, 32'h5555_AAAA, 1, 2, 1, 0, 0, 32'h0, 2'b00, 0, 3);
        total++;
        if (axi_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b expected 1", axi_err); end
        pulse_reset();
        #1;
        total++;
        if (axi_err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b expected 0", axi_err); end
    endtask

    task automatic test_reset_mid();
        int seen;
        logic [31:0] rd;
        @(negedge clock);
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.rvalid = 0; bus.rresp = 0;
        bus.arready = 1;
        dpi_req_valid = 1; dpi_req_opcode = 0; dpi_req_addr = 8'h20;
        #1;
        total++;
        if (dpi_req_deq !== 1'b1) begin bad++; $display("FAIL mid_deq: got %b expected 1", dpi_req_deq); end
        @(negedge clock);
        dpi_req_valid = 0;
        @(negedge clock);
        bus.arready = 0;
        #1;
        total++;
        if (bus.rready !== 1'b1) begin bad++; $display("FAIL mid_in_rd_data: rready=%b expected 1", bus.rready); end
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        bus.rvalid = 1; bus.rdata = 32'hBADC_0DE5;
        #1;
        seen = dpi_resp_valid ? 1 : 0;
        total++;
        if ({bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready} !== 5'b0) begin
            bad++; $display("FAIL mid_axi_idle: aw/w/b/ar/r=%b expected 00000",
                            {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready});
        end
        repeat (3) begin
            @(negedge clock); #1;
            if (dpi_resp_valid) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL mid_no_pulse: pulses=%0d expected 0", seen); end
        @(negedge clock);
        bus.rvalid = 0;
        rd = $urandom;
        run_txn(1'b0, 8'h24, 32'h0, 0, 0, 0, 0, 0, rd, 2'b00, 0, 3);
        total++;
        if (n_deq !== 1 || c_deq !== 0 || n_resp !== 1 || resp_data !== rd) begin
            bad++; $display("FAIL mid_recover: deq=%0d at=%0d pulses=%0d data=%h expected 1 0 1 %h", n_deq, c_deq, n_resp, resp_data, rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] model_mem [0:7];
        logic [31:0] slave_mem [0:7];
        bit          model_err;
        bit          op;
        int          idx;
        logic [7:0]  a;
        logic [31:0] v;
        logic [1:0]  rsp;
        pulse_reset();
        model_err = 0;
        for (int i = 0; i < 8; i++) begin model_mem[i] = '0; slave_mem[i] = '0; end
        for (int i = 0; i < 40; i++) begin
            op  = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 7);
            a   = 8'(idx * 4);
            v   = $urandom;
            rsp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(op, a, v, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), slave_mem[idx], rsp, $urandom_range(0, 1), 3);
            if (rsp != 2'b00) model_err = 1;
            if (op) begin
                model_mem[idx] = v;
                slave_mem[obs_awaddr[4:2]] = obs_wdata;
                total++;
                if (n_deq !== 1 || n_aw !== 1 || n_w !== 1 || n_resp !== 0 || obs_awaddr !== a || obs_wdata !== v || unstable) begin
                    bad++;
                    $display("FAIL rand_write[%0d]: deq=%0d aw=%0d w=%0d pulses=%0d addr=%h data=%h unstable=%b expected 1 1 1 0 %h %h 0",
                             i, n_deq, n_aw, n_w, n_resp, obs_awaddr, obs_wdata, unstable, a, v);
                end
            end else begin
                total++;
                if (n_deq !== 1 || n_ar !== 1 || n_resp !== 1 || obs_araddr !== a || resp_data !== model_mem[idx] || unstable) begin
                    bad++;
                    $display("FAIL rand_read[%0d]: deq=%0d ar=%0d pulses=%0d addr=%h data=%h unstable=%b expected 1 1 1 %h %h 0",
                             i, n_deq, n_ar, n_resp, obs_araddr, resp_data, unstable, a, model_mem[idx]);
                end
            end
        end
        total++;
        if (axi_err !== model_err) begin bad++; $display("FAIL rand_err: got %b expected %b", axi_err, model_err); end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_aw_delay();
        test_read_delay();
        test_back_to_back();
        test_rd_err();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
